// File: rtl/seg7_scan_display_if.sv
// Load-side bus for seg7_scan_display: value offer/accept handshake plus per-frame display attributes.
// SEG7_DP_EN adds the dp_mask field.
interface seg7_scan_display_if #(
  parameter int unsigned DIGITS = 8
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_value;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_blank_en;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]     dp_mask;
`endif

  modport master (
    input  load_ready,
    output load_valid, load_value, blank_mask, lz_blank_en
`ifdef SEG7_DP_EN
    , dp_mask
`endif
  );

  modport slave (
    output load_ready,
    input  load_valid, load_value, blank_mask, lz_blank_en
`ifdef SEG7_DP_EN
    , dp_mask
`endif
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment scanner with tear-free shadow/active frame update and anti-ghost dead time.
// Define SEG7_DP_EN to add per-digit decimal point (dp_mask in, num_dp out).
module seg7_scan_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_display_if.slave  load,
  output logic [DIGITS-1:0]   num_csn,
  output logic [6:0]          num_a_g
`ifdef SEG7_DP_EN
  ,
  output logic                num_dp
`endif
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_commit;

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic                w_tick;
  logic                w_wrap;
  logic                w_dead;

  logic [4*DIGITS-1:0] r_shd_val;
  logic [DIGITS-1:0]   r_shd_mask;
  logic                r_shd_lz;
  logic [4*DIGITS-1:0] r_act_val;
  logic [DIGITS-1:0]   r_act_mask;
  logic                r_act_lz;

  logic [3:0]          w_nib;
  logic                w_blank_sel;
  logic                w_nz_seen;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_csn_nxt;
  logic [6:0]          w_seg_nxt;
  logic [DIGITS-1:0]   r_csn;
  logic [6:0]          r_seg;

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   r_shd_dp;
  logic [DIGITS-1:0]   r_act_dp;
  logic                w_dp_sel;
  logic                w_dp_nxt;
  logic                r_dp;
`endif

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0:    f = 7'b1111110;
      4'h1:    f = 7'b0110000;
      4'h2:    f = 7'b1101101;
      4'h3:    f = 7'b1111001;
      4'h4:    f = 7'b0110011;
      4'h5:    f = 7'b1011011;
      4'h6:    f = 7'b1011111;
      4'h7:    f = 7'b1110000;
      4'h8:    f = 7'b1111111;
      4'h9:    f = 7'b1111011;
      4'hA:    f = 7'b1110111;
      4'hB:    f = 7'b0011111;
      4'hC:    f = 7'b1001110;
      4'hD:    f = 7'b0111101;
      4'hE:    f = 7'b1001111;
      default: f = 7'b1000111;
    endcase
    return f;
  endfunction

  assign w_tick = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));

  generate
    if (BLANK_CYC == 0) begin : g_nodead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < CW'(BLANK_CYC));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Accept and commit are exclusive: a value captured on the wrapping tick
  // only becomes pending, so it waits for the following frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: if (load.load_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_PEND;
      end
      ST_PEND: if (w_wrap) begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign load.load_ready = (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shd_val  <= '0;
      r_shd_mask <= '0;
      r_shd_lz   <= 1'b0;
      r_act_val  <= '0;
      r_act_mask <= '0;
      r_act_lz   <= 1'b0;
`ifdef SEG7_DP_EN
      r_shd_dp   <= '0;
      r_act_dp   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_shd_val  <= load.load_value;
        r_shd_mask <= load.blank_mask;
        r_shd_lz   <= load.lz_blank_en;
`ifdef SEG7_DP_EN
        r_shd_dp   <= load.dp_mask;
`endif
      end
      if (w_commit) begin
        r_act_val  <= r_shd_val;
        r_act_mask <= r_shd_mask;
        r_act_lz   <= r_shd_lz;
`ifdef SEG7_DP_EN
        r_act_dp   <= r_shd_dp;
`endif
      end
    end
  end

  // Walk from the most significant digit down so suppression stops at the first non-zero nibble.
  always_comb begin
    w_nz_seen = 1'b0;
    w_blank   = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_nz_seen = w_nz_seen | (r_act_val[4*(DIGITS-1-k) +: 4] != 4'h0);
      w_blank[DIGITS-1-k] = r_act_mask[DIGITS-1-k] |
                            (r_act_lz && !w_nz_seen && (k != DIGITS-1));
    end
  end

  always_comb begin
    w_nib       = 4'h0;
    w_blank_sel = 1'b0;
    w_csn_nxt   = '1;
    w_seg_nxt   = '1;
`ifdef SEG7_DP_EN
    w_dp_sel    = 1'b0;
    w_dp_nxt    = 1'b1;
`endif
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_act_val[4*i +: 4];
        w_blank_sel = w_blank[i];
`ifdef SEG7_DP_EN
        w_dp_sel    = r_act_dp[i];
`endif
      end
    end
    if (!w_dead) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (r_idx == IW'(i)) w_csn_nxt[i] = 1'b0;
      end
      w_seg_nxt = w_blank_sel ? '1 : ~hex_font(w_nib);
`ifdef SEG7_DP_EN
      w_dp_nxt  = ~w_dp_sel;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csn <= '1;
      r_seg <= '1;
`ifdef SEG7_DP_EN
      r_dp  <= 1'b1;
`endif
    end else begin
      r_csn <= w_csn_nxt;
      r_seg <= w_seg_nxt;
`ifdef SEG7_DP_EN
      r_dp  <= w_dp_nxt;
`endif
    end
  end

  assign num_csn = r_csn;
  assign num_a_g = r_seg;
`ifdef SEG7_DP_EN
  assign num_dp  = r_dp;
`endif

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed, table-driven bench for seg7_scan_display (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
module tb_seg7_scan_display;
  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int FRAME = 32;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] num_csn;
  logic [6:0] num_a_g;
`ifdef SEG7_DP_EN
  logic       num_dp;
`endif

  seg7_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (bus),
    .num_csn(num_csn),
    .num_a_g(num_a_g)
`ifdef SEG7_DP_EN
    ,
    .num_dp (num_dp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  mask;
    logic        lz;
    int          digit;
    logic [3:0]  csn;
    logic [6:0]  seg;
  } vec_t;

  vec_t vt[20];
  int   n_vec = 0;
  int   n_bad = 0;
  int   k     = 0;   // posedges since reset release; outputs after edge k show slot phase (k-1)%32

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, got, exp, k);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out at k=%0d", name, k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic goto_out(input int d, input int c);
    int  p;
    bit  ok;
    p  = d * 8 + c;
    ok = 1'b0;
    step();
    for (int n = 0; n < 40; n++) begin
      if (((k - 1) % FRAME) == p) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeout("goto_out");
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] m, input logic lz);
    bit hs;
    hs = 1'b0;
    bus.load_valid  = 1'b1;
    bus.load_value  = v;
    bus.blank_mask  = m;
    bus.lz_blank_en = lz;
    for (int n = 0; n < 80; n++) begin
      hs = bus.load_ready;
      step();
      if (hs) break;
    end
    bus.load_valid = 1'b0;
    if (!hs) timeout("load_handshake");
  endtask

  task automatic wait_commit(output int kc);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (bus.load_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    kc = k;
    if (!ok) timeout("wait_commit");
    else check("commit_on_frame_wrap", 32'(k % FRAME), 32'd0);
  endtask

  task automatic check_seg(input string name, input logic [3:0] csn, input logic [6:0] seg);
    check(name, {21'd0, num_csn, num_a_g}, {21'd0, csn, seg});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kc;
    int h;
    int w;

    vt[0]  = '{16'h1234, 4'h0, 1'b0, 0, 4'hE, 7'h4C};
    vt[1]  = '{16'h1234, 4'h0, 1'b0, 1, 4'hD, 7'h06};
    vt[2]  = '{16'h1234, 4'h0, 1'b0, 3, 4'h7, 7'h4F};
    vt[3]  = '{16'h0050, 4'h0, 1'b1, 3, 4'h7, 7'h7F};
    vt[4]  = '{16'h0050, 4'h0, 1'b1, 2, 4'hB, 7'h7F};
    vt[5]  = '{16'h0050, 4'h0, 1'b1, 1, 4'hD, 7'h24};
    vt[6]  = '{16'h0050, 4'h0, 1'b1, 0, 4'hE, 7'h01};
    vt[7]  = '{16'h0000, 4'h0, 1'b1, 0, 4'hE, 7'h01};
    vt[8]  = '{16'h0050, 4'h0, 1'b0, 3, 4'h7, 7'h01};
    vt[9]  = '{16'h89CD, 4'h4, 1'b0, 2, 4'hB, 7'h7F};
    vt[10] = '{16'h89CD, 4'h4, 1'b0, 3, 4'h7, 7'h00};
    vt[11] = '{16'h89CD, 4'h4, 1'b0, 1, 4'hD, 7'h31};
    vt[12] = '{16'h89CD, 4'h4, 1'b0, 0, 4'hE, 7'h42};
    vt[13] = '{16'h0E6F, 4'h0, 1'b1, 2, 4'hB, 7'h30};
    vt[14] = '{16'h0E6F, 4'h0, 1'b1, 1, 4'hD, 7'h20};
    vt[15] = '{16'h7A9B, 4'h0, 1'b0, 2, 4'hB, 7'h08};
    vt[16] = '{16'h7A9B, 4'h0, 1'b0, 3, 4'h7, 7'h0F};
    vt[17] = '{16'h7A9B, 4'h0, 1'b0, 0, 4'hE, 7'h60};
    vt[18] = '{16'h0002, 4'h0, 1'b1, 1, 4'hD, 7'h7F};
    vt[19] = '{16'h0002, 4'h0, 1'b1, 0, 4'hE, 7'h12};

    bus.load_valid  = 1'b0;
    bus.load_value  = '0;
    bus.blank_mask  = '0;
    bus.lz_blank_en = 1'b0;
`ifdef SEG7_DP_EN
    bus.dp_mask     = '0;
`endif

    // Reset state, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check_seg("reset_outputs", 4'hF, 7'h7F);
    check("reset_ready", 32'(bus.load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    k = 0;

    step();
    check_seg("first_slot_dead", 4'hF, 7'h7F);

    // Table: each value displayed for one full slot (2 dead + 6 lit cycles).
    for (int i = 0; i < 20; i++) begin
      load(vt[i].val, vt[i].mask, vt[i].lz);
      wait_commit(kc);
      goto_out(vt[i].digit, 0);
      for (int c = 0; c < 8; c++) begin
        if (c < int'(BLANK_CYC))
          check_seg($sformatf("vec%0d_c%0d_dead", i, c), 4'hF, 7'h7F);
        else
          check_seg($sformatf("vec%0d_c%0d", i, c), vt[i].csn, vt[i].seg);
        if (c < 7) step();
      end
    end

    // Second offer held while first is pending.
    load(16'h00AB, 4'h0, 1'b0);
    check("hold_ready_low", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b1;
    bus.load_value = 16'hFFFF;
    w = -1;
    for (int n = 0; n < 80; n++) begin
      if (bus.load_ready) begin
        w = k;
        break;
      end
      step();
    end
    if (w < 0) timeout("hold_wait_ready");
    else check("hold_ready_at_wrap", 32'(w % FRAME), 32'd0);
    step();
    bus.load_valid = 1'b0;
    check("hold_second_captured", 32'(bus.load_ready), 32'd0);
    goto_out(0, 4);
    check_seg("hold_d0_b", 4'hE, 7'h60);
    goto_out(1, 4);
    check_seg("hold_d1_A", 4'hD, 7'h08);
    goto_out(3, 4);
    check_seg("hold_d3_0", 4'h7, 7'h01);
    wait_commit(kc);
    check("hold_commit_frame_later", 32'(kc - w), 32'd32);
    goto_out(0, 4);
    check_seg("hold_d0_F", 4'hE, 7'h38);
    goto_out(3, 4);
    check_seg("hold_d3_F", 4'h7, 7'h38);

    // Handshake on the wrapping tick commits one frame later.
    for (int n = 0; n < 40; n++) begin
      if ((k % FRAME) == FRAME - 1) break;
      step();
    end
    load(16'h1234, 4'h0, 1'b0);
    h = k;
    check("bnd_hs_on_wrap", 32'(h % FRAME), 32'd0);
    check("bnd_ready_low", 32'(bus.load_ready), 32'd0);
    goto_out(0, 4);
    check_seg("bnd_old_value_kept", 4'hE, 7'h38);
    wait_commit(kc);
    check("bnd_commit_delay", 32'(kc - h), 32'd32);
    goto_out(0, 4);
    check_seg("bnd_new_value", 4'hE, 7'h4C);

`ifdef SEG7_DP_EN
    bus.dp_mask = 4'b0010;
    load(16'h1234, 4'h0, 1'b0);
    wait_commit(kc);
    bus.dp_mask = 4'b0000;
    for (int n = 0; n < FRAME; n++) begin
      int ph;
      step();
      ph = (k - 1) % FRAME;
      check($sformatf("dp_ph%0d", ph), 32'(num_dp),
            ((ph / 8) == 1 && (ph % 8) >= 2) ? 32'd0 : 32'd1);
    end
`endif

    // Reset mid-scan with a pending value that must be discarded.
    load(16'h1111, 4'h0, 1'b0);
    check("pre_reset_pending", 32'(bus.load_ready), 32'd0);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check_seg("midscan_reset_outputs", 4'hF, 7'h7F);
    check("midscan_reset_ready", 32'(bus.load_ready), 32'd1);
    step();
    reset = 1'b0;
    k = 0;
    goto_out(0, 2);
    check_seg("post_reset_d0", 4'hE, 7'h01);
    goto_out(0, 2);
    check_seg("post_reset_discard", 4'hE, 7'h01);
    check("post_reset_ready", 32'(bus.load_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal >= 4).
REQ-003 SHALL have parameter BLANK_CYC, default 4, anti-ghost dead cycles at slot start (legal 0..SCAN_DIV-2).
REQ-004 SHALL have port clk  input  1  sole clock, all flops on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1  new display value offered.
REQ-007 SHALL have port load_ready  output  1  module can accept a value.
REQ-008 SHALL have port load_value  input  4*DIGITS  hex nibbles, nibble i shown on digit i (digit 0 rightmost).
REQ-009 SHALL have port blank_mask  input  DIGITS  per-digit force-blank, sampled with load_value.
REQ-010 SHALL have port lz_blank_en  input  1  leading-zero suppression, sampled with load_value.
REQ-011 SHALL have port num_csn  output  DIGITS  digit enables, active-low.
REQ-012 SHALL have port num_a_g  output  7  segments, active-low, bit6=a ... bit0=g.

Function
REQ-013 SHALL count cycles 0..SCAN_DIV-1 in a slot counter; tick when counter = SCAN_DIV-1, counter then wraps to 0.
REQ-014 SHALL advance digit index on tick, DIGITS-1 wraps to 0 (frame boundary).
REQ-015 SHALL capture load_value/blank_mask/lz_blank_en into a shadow register on load_valid && load_ready, setting a pending flag.
REQ-016 SHALL drive load_ready = !pending; while pending, load_valid is ignored and shadow is held.
REQ-017 SHALL copy shadow to active register and clear pending only on the tick that wraps index to 0 (tear-free frame update).
REQ-018 SHALL, for a handshake in the same cycle as the wrapping tick, capture into shadow and commit at the next frame boundary, not the current one.
REQ-019 SHALL decode active nibble via standard hex font 0-9,A,b,C,d,E,F (active-high abcdefg: 0=1111110, 8=1111111, F=1000111), inverted to active-low.
REQ-020 SHALL blank digit i when blank_mask[i]=1, or lz_blank_en=1 and all nibbles >= i are zero and i != 0; digit 0 is never blanked by suppression.
REQ-021 SHALL drive num_csn and num_a_g all-ones during slot counter values 0..BLANK_CYC-1 of every slot.
REQ-022 SHALL otherwise drive num_csn with only bit[index] low, num_a_g = decoded pattern, or all-ones if digit blanked (csn still low).
REQ-023 SHALL register num_csn and num_a_g; they reflect slot counter/index one cycle later.

Reset
REQ-024 SHALL on reset force counter=0, index=0, active=0, shadow=0, masks=0, lz=0, pending=0.
REQ-025 SHALL hold num_csn=all-ones, num_a_g=7'h7F, load_ready=1 on reset, asynchronously.
REQ-026 SHALL discard a pending uncommitted value when reset is asserted mid-frame.

Configuration
REQ-027 SHALL compile in, when SEG7_DP_EN is defined, input dp_mask [DIGITS-1:0] (sampled with load_value) and output num_dp (active-low), low when digit dp bit set and digit slot active outside dead time.
REQ-028 SHALL, without SEG7_DP_EN, have neither dp_mask nor num_dp; all other behaviour identical.

Verification (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
REQ-029 SHALL cover reset: assert reset mid-scan -> num_csn=4'hF, num_a_g=7'h7F, load_ready=1 immediately, scan restarts at digit 0.
REQ-030 SHALL cover scan: load 16'h1234 -> after next frame, digit0 slot shows num_csn=4'b1110, num_a_g=~7'b0110011 ('4') for 6 cycles after 2 dead cycles; digits cycle every 8 cycles.
REQ-031 SHALL cover handshake: load 16'h00AB then hold load_valid with 16'hFFFF -> load_ready=0 until frame wrap, 16'h00AB displayed one full frame, then 16'hFFFF accepted.
REQ-032 SHALL cover suppression: 16'h0050, lz_blank_en=1 -> digits 3,2 segments 7'h7F, digit1 '5', digit0 '0' (7'b0000001).
REQ-033 SHALL cover boundary: handshake on wrapping tick -> value commits one frame later, not immediately.
REQ-034 SHALL cover SEG7_DP_EN: dp_mask=4'b0010 -> num_dp=0 only during digit1 active cycles.
